systolic_matvec_engine: RTL
===========================

// Module: systolic_matvec_engine
// PURPOSE
//  Parametrised successor to the vectored MAC/FIFO array. Computes C = A x B: A is NxN, B is an N-vector, C is an N-vector.
//  Contains per-row A FIFOs, a shared B FIFO, a skewed systolic PE column and a control FSM.
//  Has a start/ready/valid handshake, so the memory-fetch logic and the result consumer work with no external sequencing.
// PARAMETERS
//  N      8   lanes: number of rows, and elements per row / vector
//  DW     8   operand width, unsigned
//  AW    24   accumulator / C element width; must satisfy AW >= 2*DW
//  DEPTH  16  entries per FIFO; must satisfy DEPTH >= N, power of two
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  a_wr_en      in   N        push enable, one bit per row FIFO i
//  a_wr_data    in   N x DW   pushed element A[i][k]; row i sends k in order 0..N-1
//  b_wr_en      in   1        push enable for the B FIFO
//  b_wr_data    in   DW       pushed element B[k], in order 0..N-1
//  a_full       out  N        row FIFO i is full
//  b_full       out  1        B FIFO is full
//  start        in   1        request one mat-vec pass
//  busy         out  1        high when state != IDLE
//  c_valid      out  1        result C is presented
//  c_ready      in   1        consumer accepts C
//  c_data       out  N x AW   C[i]
//  done         out  1        one-cycle pulse when C is accepted
//  err_overflow out  1        sticky; set by a push to a full FIFO
// BEHAVIOUR
//  Reset: all FIFOs empty. state=IDLE. c_data=0. c_valid=busy=done=err_overflow=0. PE pipeline cleared.
//    Reset applies mid-operation: the in-flight pass is discarded.
//  FIFOs: show-ahead; q is the head combinationally; pop and use happen in the same cycle.
//    A push to a full FIFO is dropped and sets err_overflow; it stays set until rst.
//    Pushes are legal in every state, so the next operand set can be buffered during RUN/OUT.
//    Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  FSM states: IDLE, WAIT, RUN, OUT.
//    IDLE -start-> WAIT. start outside IDLE is ignored (no queuing).
//    WAIT -> RUN in the cycle after every A FIFO count >= N and B count >= N. Entering RUN clears all accumulators.
//    RUN lasts exactly 2N-1 cycles, t=0..2N-2.
//      B FIFO pops at t=0..N-1 into a shift chain; row i sees B[k] at t=k+i.
//      A FIFO i pops at t=i..i+N-1; acc[i] += A[i][k]*B[k] at t=k+i.
//    RUN -> OUT after t=2N-2. c_valid=1 and c_data=acc, both registered; c_valid rises 2N-1 cycles after RUN entry.
//    OUT: c_data and c_valid stay stable while c_ready=0.
//      When c_valid&&c_ready: done=1 that cycle, then IDLE next cycle with c_valid=0 and c_data holding its last value.
//  Arithmetic: product is 2*DW bits, zero-extended to AW. Accumulation wraps modulo 2^AW (see CONFIGURATION).
// CONFIGURATION
//  MAC_SATURATE_EN defined: each accumulate clamps to 2^AW-1 instead of wrapping.
//  MAC_SATURATE_EN undefined: accumulation wraps modulo 2^AW.
// STRUCTURE
//  Package mac_pkg holds:
//    - state enum typedef (IDLE/WAIT/RUN/OUT)
//    - default DW/AW constants
//    - function sat_add(acc, prod) for the saturating path
//  Sub-module sync_fifo (DW, DEPTH), instantiated N+1 times; show-ahead with a count output.
//  The PE column (skew registers + accumulators) is inline generate logic, not a separate module.
// TESTING
//  Common settings: N=4, DW=8, AW=24, DEPTH=16 unless stated otherwise.
//  1 Reset: hold rst 2 cycles, with start and pushes active.
//    -> all outputs 0, FIFOs empty, state IDLE.
//  2 A=identity, B=[1,2,3,4], then start.
//    -> RUN entry 2 cycles after start; c_valid 7 cycles after RUN entry; c_data=[1,2,3,4]; done pulses on accept.
//  3 N=8, AW=16, all A=B=255.
//    -> without macro: every C[i]=61448 (520200 mod 65536). With MAC_SATURATE_EN: every C[i]=65535.
//  4 Push only 3 B elements, then start.
//    -> FSM holds in WAIT with busy=1; the 4th B push -> RUN next cycle.
//  5 Hold c_ready=0 for 10 cycles, push the next operand set and pulse start during OUT.
//    -> c_data stable; the start is ignored; after accept, a new start runs the second set with correct C.
//  6 Push 17 elements into row 0 (DEPTH=16).
//    -> 17th dropped, err_overflow=1 and sticky; rst asserted mid-RUN -> next cycle IDLE, c_valid=0, FIFOs empty.

Source files
------------

// File: rtl/systolic_matvec_engine_pkg.sv
// Shared types and helpers for the systolic mat-vec engine: FSM state encoding,
// default operand/accumulator widths and the clamping adder.
// Pure declarations: no latency, no backpressure.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 24;

  // Working width of sat_add; callers zero-extend into it (AW must be < SAT_W).
  localparam int SAT_W = 64;

  // acc + prod clamped to 2^aw-1 instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] prod,
                                               input int               aw);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {1'b0, prod};
    lim = ((SAT_W+1)'(1) << aw) - (SAT_W+1)'(1);
    if (sum > lim) sat_add = lim[SAT_W-1:0];
    else           sat_add = sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/systolic_matvec_engine_if.sv
// Operand push, control handshake and result bus of the mat-vec engine.
// Wires only: no latency.
// master drives pushes/start/c_ready; slave (the engine) drives full flags and results.
interface systolic_matvec_engine_if #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 24
);
  logic [N-1:0]         a_wr_en;
  logic [N-1:0][DW-1:0] a_wr_data;
  logic                 b_wr_en;
  logic [DW-1:0]        b_wr_data;
  logic [N-1:0]         a_full;
  logic                 b_full;
  logic                 start;
  logic                 busy;
  logic                 c_valid;
  logic                 c_ready;
  logic [N-1:0][AW-1:0] c_data;
  logic                 done;
  logic                 err_overflow;

  modport master (
    output a_wr_en, a_wr_data, b_wr_en, b_wr_data, start, c_ready,
    input  a_full, b_full, busy, c_valid, c_data, done, err_overflow
  );

  modport slave (
    input  a_wr_en, a_wr_data, b_wr_en, b_wr_data, start, c_ready,
    output a_full, b_full, busy, c_valid, c_data, done, err_overflow
  );
endinterface

// File: rtl/systolic_matvec_engine_fifo.sv
// Show-ahead synchronous FIFO with occupancy count (DEPTH must be a power of two).
// Head visible combinationally; pop and use in the same cycle, push visible next cycle.
// Push while full is dropped and flagged on ovf_o unless a pop frees the slot that cycle.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_dat_i,
  input  logic                     rd_en_i,
  output logic [DW-1:0]            rd_dat_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, do_wr, do_rd;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_rd    = rd_en_i && !empty;
  assign do_wr    = wr_en_i && (!full || do_rd);
  assign ovf_o    = wr_en_i && full && !do_rd;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign full_o   = full;
  assign count_o  = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/systolic_matvec_engine.sv
// C = A x B mat-vec engine: per-row A FIFOs, shared B FIFO, skewed PE column, control FSM.
// start -> WAIT until operands buffered -> RUN 2N-1 cycles -> registered C with c_valid.
// Result held stable until c_ready; pushes accepted in any state. MAC_SATURATE_EN: clamp accumulators.
module systolic_matvec_engine
  import mac_pkg::*;
#(
  parameter int N     = 8,       // N >= 2
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,  // AW >= 2*DW, AW < SAT_W
  parameter int DEPTH = 16       // DEPTH >= N, power of two
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_matvec_engine_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(2 * N);

  state_t               state_q;
  logic [TW-1:0]        t_q;
  logic                 busy_q, c_valid_q, err_q;
  logic [N-1:0][AW-1:0] c_data_q;

  logic [DW-1:0]        a_head [N];
  logic [CW-1:0]        a_cnt  [N];
  logic [N-1:0]         a_pop, a_ovf, a_full;
  logic [DW-1:0]        b_head;
  logic [CW-1:0]        b_cnt;
  logic                 b_pop, b_ovf, b_full;
  logic [DW-1:0]        bsk_q  [N-1];
  logic [AW-1:0]        acc_d  [N];
  logic                 run, enter_run, cnt_ok;

  assign run       = (state_q == RUN);
  assign enter_run = (state_q == WAIT) && cnt_ok;
  assign b_pop     = run && (t_q < TW'(N));

  // Operand buffers.
  for (genvar i = 0; i < N; i++) begin : g_a_fifo
    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (bus.a_wr_en[i]),
      .wr_dat_i (bus.a_wr_data[i]),
      .rd_en_i  (a_pop[i]),
      .rd_dat_o (a_head[i]),
      .full_o   (a_full[i]),
      .count_o  (a_cnt[i]),
      .ovf_o    (a_ovf[i])
    );
  end

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_b_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (bus.b_wr_en),
    .wr_dat_i (bus.b_wr_data),
    .rd_en_i  (b_pop),
    .rd_dat_o (b_head),
    .full_o   (b_full),
    .count_o  (b_cnt),
    .ovf_o    (b_ovf)
  );

  // A full row in every A FIFO plus a full B vector must be buffered before RUN.
  always_comb begin
    cnt_ok = (b_cnt >= CW'(N));
    for (int i = 0; i < N; i++) begin
      if (a_cnt[i] < CW'(N)) cnt_ok = 1'b0;
    end
  end

  // B skew chain: row i reads B[k] i cycles after row 0 popped it from the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N - 1; i++) bsk_q[i] <= '0;
    end else begin
      bsk_q[0] <= b_head;
      for (int i = 1; i < N - 1; i++) bsk_q[i] <= bsk_q[i-1];
    end
  end

  // PE column: row i is active for t in [i, i+N-1]; the modular subtraction
  // puts t < i far above N, so one compare covers both ends of the window.
  for (genvar i = 0; i < N; i++) begin : g_pe
    logic [DW-1:0]   b_op;
    logic [TW-1:0]   rel;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_q;

    if (i == 0) begin : g_head
      assign b_op = b_head;
    end else begin : g_skew
      assign b_op = bsk_q[i-1];
    end

    assign rel      = t_q - TW'(i);
    assign a_pop[i] = run && (rel < TW'(N));
    assign prod     = (2*DW)'(a_head[i]) * (2*DW)'(b_op);
`ifdef MAC_SATURATE_EN
    assign sum      = AW'(sat_add(SAT_W'(acc_q), SAT_W'(prod), AW));
`else
    assign sum      = acc_q + AW'(prod);
`endif
    assign acc_d[i] = a_pop[i] ? sum : acc_q;

    // Accumulator: cleared on RUN entry, otherwise takes the MAC result.
    always_ff @(posedge clk) begin
      if (rst || enter_run) acc_q <= '0;
      else                  acc_q <= acc_d[i];
    end
  end

  // Control FSM with registered busy/c_valid/c_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      busy_q    <= 1'b0;
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_ok) begin
            state_q <= RUN;
            t_q     <= '0;
          end
        end
        RUN: begin
          if (t_q == TW'(2*N - 2)) begin
            state_q   <= OUT;
            c_valid_q <= 1'b1;
            // acc_d includes the last row's final accumulate of this cycle.
            for (int i = 0; i < N; i++) c_data_q[i] <= acc_d[i];
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        OUT: begin
          if (bus.c_ready) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            c_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overflow flag: any dropped push from any FIFO.
  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (|a_ovf || b_ovf) err_q <= 1'b1;
  end

  assign bus.a_full       = a_full;
  assign bus.b_full       = b_full;
  assign bus.busy         = busy_q;
  assign bus.c_valid      = c_valid_q;
  assign bus.c_data       = c_data_q;
  assign bus.done         = c_valid_q && bus.c_ready;
  assign bus.err_overflow = err_q;

endmodule
